// File: rtl/mem_bus_arb_pkg.sv
// Shared definitions for the memory bus arbiter: state encoding, requester ids,
// bus width and the beat-counter width helper.
package mem_bus_arb_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IREAD  = 3'd1,
        DREAD  = 3'd2,
        DWRITE = 3'd3,
        TURN   = 3'd4
    } state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    // Beat counter width: clog2(words), never narrower than one bit.
    function automatic int unsigned beat_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arb_prio.sv
// Grant decision for the bus arbiter. Data side wins by default; once MAX_DSTREAK
// consecutive D grants have gone by with an instruction fill waiting, I is forced.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_ireq, i_dreq : request levels from the I and D sides
//   i_idle         : arbiter is in IDLE
//   i_grant        : a grant is being made this cycle
//   o_grant_id_c   : combinational winner (REQ_I / REQ_D)
module mem_bus_arb_prio
    import mem_bus_arb_pkg::*;
#(
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ireq,
    input  logic i_dreq,
    input  logic i_idle,
    input  logic i_grant,
    output logic o_grant_id_c
);

    localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);

    logic [SW-1:0] r_dstreak;
    logic          w_forced_i;

    assign w_forced_i   = i_ireq && (r_dstreak == SW'(MAX_DSTREAK));
    assign o_grant_id_c = (i_dreq && !w_forced_i) ? REQ_D : REQ_I;

    // Streak counts only D grants that overtook a waiting fill.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_dstreak <= '0;
        end else if (i_idle && i_grant) begin
            if ((o_grant_id_c == REQ_D) && i_ireq) begin
                if (r_dstreak != SW'(MAX_DSTREAK)) begin
                    r_dstreak <= r_dstreak + SW'(1);
                end
            end else begin
                r_dstreak <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arb.sv
// External memory bus arbiter between the instruction-fill and data requesters.
// Sequences LINE_WORDS-beat line reads and single-beat writes with a one-cycle
// turnaround after each write.
// Ports:
//   CLK, MRST_N                       : clock, synchronous active-low reset
//   i_req/i_addr, i_beat/i_done       : instruction fill request and beat/done pulses
//   d_req/d_we/d_addr/d_wdata         : data request (write or line read)
//   d_beat/d_done                     : data beat/done pulses
//   rd_data                           : registered read word for both sides
//   Bus/Addr/Read/Write/Valid         : memory bus
//   busy                              : not IDLE
//   stat_ifill/dread/dwrite/wait      : statistics, built only with BUS_ARB_STATS_EN
module mem_bus_arb
    import mem_bus_arb_pkg::*;
#(
    parameter int unsigned LINE_WORDS  = 4,
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic              CLK,
    input  logic              MRST_N,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_addr,
    output logic              i_beat,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_beat,
    output logic              d_done,
    output logic [DATA_W-1:0] rd_data,
    inout  wire  [DATA_W-1:0] Bus,
    output logic [DATA_W-1:0] Addr,
    output logic              Read,
    output logic              Write,
    input  logic              Valid,
    output logic              busy,
    output logic [31:0]       stat_ifill,
    output logic [31:0]       stat_dread,
    output logic [31:0]       stat_dwrite,
    output logic [31:0]       stat_wait
);

    localparam int unsigned BW = beat_w(LINE_WORDS);

    state_e            r_state, w_state;
    logic [DATA_W-1:0] r_addr, w_addr;
    logic [DATA_W-1:0] r_wdata, w_wdata;
    logic [DATA_W-1:0] r_rd_data, w_rd_data;
    logic [BW-1:0]     r_beat_cnt, w_beat_cnt;
    logic              r_read, w_read;
    logic              r_write, w_write;
    logic              r_busy;
    logic              r_i_beat, w_i_beat, r_i_done, w_i_done;
    logic              r_d_beat, w_d_beat, r_d_done, w_d_done;
    logic              w_idle, w_grant, w_grant_id;

    assign w_idle  = (r_state == IDLE);
    assign w_grant = w_idle && (i_req || d_req);

    mem_bus_arb_prio #(
        .MAX_DSTREAK (MAX_DSTREAK)
    ) u_prio (
        .i_clk        (CLK),
        .i_rst_n      (MRST_N),
        .i_ireq       (i_req),
        .i_dreq       (d_req),
        .i_idle       (w_idle),
        .i_grant      (w_grant),
        .o_grant_id_c (w_grant_id)
    );

    // Next-state and next-output logic.
    always_comb begin
        w_state    = r_state;
        w_addr     = r_addr;
        w_wdata    = r_wdata;
        w_rd_data  = r_rd_data;
        w_beat_cnt = r_beat_cnt;
        w_read     = r_read;
        w_write    = r_write;
        w_i_beat   = 1'b0;
        w_i_done   = 1'b0;
        w_d_beat   = 1'b0;
        w_d_done   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_beat_cnt = '0;
                    if (w_grant_id == REQ_D) begin
                        w_addr = d_addr;
                        if (d_we) begin
                            w_state = DWRITE;
                            w_write = 1'b1;
                            w_wdata = d_wdata;
                        end else begin
                            w_state = DREAD;
                            w_read  = 1'b1;
                        end
                    end else begin
                        w_state = IREAD;
                        w_addr  = i_addr;
                        w_read  = 1'b1;
                    end
                end
            end
            IREAD, DREAD: begin
                if (Valid) begin
                    w_rd_data  = Bus;
                    w_beat_cnt = r_beat_cnt + BW'(1);
                    w_addr     = r_addr + 32'd4;
                    w_i_beat   = (r_state == IREAD);
                    w_d_beat   = (r_state == DREAD);
                    if (r_beat_cnt == BW'(LINE_WORDS - 1)) begin
                        w_read   = 1'b0;
                        w_state  = IDLE;
                        w_i_done = (r_state == IREAD);
                        w_d_done = (r_state == DREAD);
                    end
                end
            end
            DWRITE: begin
                if (Valid) begin
                    w_write  = 1'b0;
                    w_d_done = 1'b1;
                    w_state  = TURN;
                end
            end
            TURN: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
                w_read  = 1'b0;
                w_write = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (!MRST_N) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd_data  <= '0;
            r_beat_cnt <= '0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_busy     <= 1'b0;
            r_i_beat   <= 1'b0;
            r_i_done   <= 1'b0;
            r_d_beat   <= 1'b0;
            r_d_done   <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_rd_data  <= w_rd_data;
            r_beat_cnt <= w_beat_cnt;
            r_read     <= w_read;
            r_write    <= w_write;
            r_busy     <= (w_state != IDLE);
            r_i_beat   <= w_i_beat;
            r_i_done   <= w_i_done;
            r_d_beat   <= w_d_beat;
            r_d_done   <= w_d_done;
        end
    end

    // Bus is driven only while the write strobe is up.
    assign Bus     = r_write ? r_wdata : {DATA_W{1'bz}};
    assign Addr    = r_addr;
    assign Read    = r_read;
    assign Write   = r_write;
    assign rd_data = r_rd_data;
    assign busy    = r_busy;
    assign i_beat  = r_i_beat;
    assign i_done  = r_i_done;
    assign d_beat  = r_d_beat;
    assign d_done  = r_d_done;

`ifdef BUS_ARB_STATS_EN
    logic [31:0] r_stat_ifill, r_stat_dread, r_stat_dwrite, r_stat_wait;

    // Completion and wait-cycle counters, free-running with wrap.
    always_ff @(posedge CLK) begin
        if (!MRST_N) begin
            r_stat_ifill  <= '0;
            r_stat_dread  <= '0;
            r_stat_dwrite <= '0;
            r_stat_wait   <= '0;
        end else begin
            if (w_i_done) r_stat_ifill <= r_stat_ifill + 32'd1;
            if (w_d_done && (r_state == DREAD)) r_stat_dread <= r_stat_dread + 32'd1;
            if (w_d_done && (r_state == DWRITE)) r_stat_dwrite <= r_stat_dwrite + 32'd1;
            if ((r_read || r_write) && !Valid) r_stat_wait <= r_stat_wait + 32'd1;
        end
    end

    assign stat_ifill  = r_stat_ifill;
    assign stat_dread  = r_stat_dread;
    assign stat_dwrite = r_stat_dwrite;
    assign stat_wait   = r_stat_wait;
`else
    assign stat_ifill  = '0;
    assign stat_dread  = '0;
    assign stat_dwrite = '0;
    assign stat_wait   = '0;
`endif

endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed bench for mem_bus_arb: a vector table of single-requester transactions
// plus hand-written reset, collision, starvation and stall sequences.
module tb_mem_bus_arb;

    localparam int unsigned LW = 4;
    localparam int unsigned MD = 4;

    logic        CLK = 1'b0;
    logic        MRST_N;
    logic        i_req, d_req, d_we, Valid;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_beat, i_done, d_beat, d_done, Read, Write, busy;
    logic [31:0] rd_data, Addr;
    logic [31:0] stat_ifill, stat_dread, stat_dwrite, stat_wait;
    wire  [31:0] Bus;
    logic        tb_oe;
    logic [31:0] tb_data;

    int checks = 0;
    int errors = 0;

    assign Bus = tb_oe ? tb_data : 32'bz;

    always #5 CLK = ~CLK;

    mem_bus_arb #(.LINE_WORDS(LW), .MAX_DSTREAK(MD)) dut (
        .CLK(CLK), .MRST_N(MRST_N),
        .i_req(i_req), .i_addr(i_addr), .i_beat(i_beat), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_beat(d_beat), .d_done(d_done), .rd_data(rd_data),
        .Bus(Bus), .Addr(Addr), .Read(Read), .Write(Write), .Valid(Valid),
        .busy(busy), .stat_ifill(stat_ifill), .stat_dread(stat_dread),
        .stat_dwrite(stat_dwrite), .stat_wait(stat_wait)
    );

    typedef struct {
        logic        ireq;
        logic        dreq;
        logic        dwe;
        logic [31:0] addr;
        logic [31:0] data;
        int          waits;
        logic        exp_read;
        logic        exp_write;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Strobes must never overlap.
    always @(negedge CLK) begin
        if (MRST_N === 1'b1) begin
            checks++;
            if (Read && Write) begin
                errors++;
                $display("FAIL strobe_overlap: got Read=1 Write=1 expected not both at %0t", $time);
            end
        end
    end

    // Called the cycle after the grant; returns with the final beat/done visible.
    task automatic run_read(input logic is_i, input logic [31:0] base, input logic [31:0] pat,
                            input int stall_at, input int stall_len);
        logic [31:0] w0, f0;
        w0 = stat_wait;
        f0 = is_i ? stat_ifill : stat_dread;
        for (int k = 0; k < int'(LW); k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    Valid = 1'b0; tb_oe = 1'b0;
                    tick();
                    check("stall_addr", Addr, base + 32'(4 * k));
                    check("stall_read", 32'(Read), 32'd1);
                    check("stall_beat", 32'({i_beat, d_beat}), 32'd0);
                end
            end
            check("beat_addr", Addr, base + 32'(4 * k));
            check("beat_read", 32'(Read), 32'd1);
            Valid = 1'b1; tb_oe = 1'b1; tb_data = pat + 32'(k);
            tick();
            check("beat_pulse", 32'(is_i ? i_beat : d_beat), 32'd1);
            check("other_beat", 32'(is_i ? d_beat : i_beat), 32'd0);
            check("rd_data", rd_data, pat + 32'(k));
            check("read_done", 32'(is_i ? i_done : d_done), 32'(k == int'(LW) - 1));
        end
        Valid = 1'b0; tb_oe = 1'b0;
        check("read_drop", 32'(Read), 32'd0);
        check("busy_after_read", 32'(busy), 32'd0);
`ifdef BUS_ARB_STATS_EN
        check("stat_wait_read", stat_wait - w0, 32'(stall_len));
        check("stat_fill", (is_i ? stat_ifill : stat_dread) - f0, 32'd1);
`endif
    endtask

    // Called the cycle after the grant; returns with the arbiter back in IDLE.
    task automatic run_write(input logic [31:0] addr, input logic [31:0] data, input int waits);
        logic [31:0] w0, f0;
        w0 = stat_wait;
        f0 = stat_dwrite;
        check("wr_strobe", 32'({Write, Read}), 32'b10);
        check("wr_addr", Addr, addr);
        check("wr_bus", Bus, data);
        for (int w = 0; w < waits; w++) begin
            Valid = 1'b0;
            tick();
            check("wr_hold", 32'(Write), 32'd1);
            check("wr_bus_hold", Bus, data);
            check("wr_no_done", 32'(d_done), 32'd0);
        end
        Valid = 1'b1;
        tick();
        Valid = 1'b0;
        check("wr_done", 32'(d_done), 32'd1);
        check("wr_drop", 32'(Write), 32'd0);
        check("wr_turn_busy", 32'(busy), 32'd1);
        tick();
        check("wr_idle", 32'(busy), 32'd0);
        check("wr_single_done", 32'(d_done), 32'd0);
        check("turn_no_grant", 32'({Read, Write}), 32'd0);
`ifdef BUS_ARB_STATS_EN
        check("stat_wait_write", stat_wait - w0, 32'(waits));
        check("stat_dwrite", stat_dwrite - f0, 32'd1);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_3000, 32'h1111_0000, 0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 3, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0000_0050, 0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_0004, 32'h1234_5678, 0, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'hC0DE_0000, 0, 1'b1, 1'b0, 1'b1};

        MRST_N = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; Valid = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; tb_oe = 1'b0; tb_data = '0;
        tick(); tick();
        check("rst_addr", Addr, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_strobes", 32'({Read, Write}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", 32'({i_beat, i_done, d_beat, d_done}), 32'd0);
        MRST_N = 1'b1;

        // Reset in the middle of a fill abandons it silently.
        i_req = 1'b1; i_addr = 32'h0000_0500;
        tick();
        check("pre_rst_grant", Addr, 32'h0000_0500);
        Valid = 1'b1; tb_oe = 1'b1; tb_data = 32'h55;
        tick();
        check("pre_rst_beat", 32'(i_beat), 32'd1);
        Valid = 1'b0; tb_oe = 1'b0; MRST_N = 1'b0; i_addr = 32'h0000_0100;
        for (int c = 0; c < 2; c++) begin
            tick();
            check("midrst_read", 32'(Read), 32'd0);
            check("midrst_busy", 32'(busy), 32'd0);
            check("midrst_no_done", 32'(i_done), 32'd0);
        end
        check("midrst_rd_data", rd_data, 32'd0);
        MRST_N = 1'b1;
        tick();
        check("restart_addr", Addr, 32'h0000_0100);
        run_read(1'b1, 32'h0000_0100, 32'h0000_00A0, -1, 0);
        i_req = 1'b0;

        // Single-requester vector table.
        for (int v = 0; v < 6; v++) begin
            i_req = vecs[v].ireq; d_req = vecs[v].dreq; d_we = vecs[v].dwe;
            i_addr = vecs[v].addr; d_addr = vecs[v].addr; d_wdata = vecs[v].data;
            tick();
            check("vec_read", 32'(Read), 32'(vecs[v].exp_read));
            check("vec_write", 32'(Write), 32'(vecs[v].exp_write));
            check("vec_busy", 32'(busy), 32'(vecs[v].exp_busy));
            if (vecs[v].exp_busy) begin
                check("vec_addr", Addr, vecs[v].addr);
                if (vecs[v].dwe) run_write(vecs[v].addr, vecs[v].data, vecs[v].waits);
                else run_read(vecs[v].ireq, vecs[v].addr, vecs[v].data, -1, 0);
            end
            i_req = 1'b0; d_req = 1'b0;
        end

        // Collision: D read goes first, I follows.
        i_req = 1'b1; i_addr = 32'h0000_0800;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0900;
        tick();
        check("coll_d_first", Addr, 32'h0000_0900);
        run_read(1'b0, 32'h0000_0900, 32'h0000_0D00, -1, 0);
        d_req = 1'b0;
        tick();
        check("coll_i_second", Addr, 32'h0000_0800);
        run_read(1'b1, 32'h0000_0800, 32'h0000_0E00, -1, 0);
        i_req = 1'b0;

        // Starvation guard: four D writes, then the waiting fill, then D again.
        i_req = 1'b1; i_addr = 32'h0000_0A00;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0B00; d_wdata = 32'h0BAD_F00D;
        for (int g = 0; g < int'(MD); g++) begin
            tick();
            check("starve_d_grant", 32'(Write), 32'd1);
            run_write(32'h0000_0B00, 32'h0BAD_F00D, 0);
        end
        tick();
        check("starve_i_forced", 32'({Read, Write}), 32'b10);
        check("starve_i_addr", Addr, 32'h0000_0A00);
        run_read(1'b1, 32'h0000_0A00, 32'h0000_0F00, -1, 0);
        i_req = 1'b0;
        tick();
        check("starve_d_resume", 32'(Write), 32'd1);
        run_write(32'h0000_0B00, 32'h0BAD_F00D, 0);
        d_req = 1'b0;

        // Ten-cycle Valid stall in the middle of a line.
        i_req = 1'b1; i_addr = 32'h0000_0100;
        tick();
        check("stall_grant", Addr, 32'h0000_0100);
        run_read(1'b1, 32'h0000_0100, 32'h0000_00A0, 2, 10);
        i_req = 1'b0;

`ifndef BUS_ARB_STATS_EN
        check("stat_off_ifill", stat_ifill, 32'd0);
        check("stat_off_dread", stat_dread, 32'd0);
        check("stat_off_dwrite", stat_dwrite, 32'd0);
        check("stat_off_wait", stat_wait, 32'd0);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arb.md
Name: mem_bus_arb

Overview:
- Arbitrates the single external memory bus (Bus/Addr/Read/Write/Valid) between the instruction-fill requester and the data-side requester.
- Sequences multi-beat line reads and single-beat writes.
- Sits between the IF/MEM cache controllers and the memory system, replacing direct bus drive by the mem stage.
- Data side has fixed priority, with a starvation guard that guarantees instruction fills make progress.

Parameters:
- LINE_WORDS, 4, words per read fill; power of two, range 1..16.
- MAX_DSTREAK, 4, consecutive D grants allowed while i_req is pending before I is forced; range ≥1.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- MRST_N  input  1  synchronous active-low reset.
- i_req  input  1  instruction line-fill request; level, held until i_done.
- i_addr  input  32  fill base address; word aligned, line aligned.
- i_beat  output  1  one-cycle pulse: rd_data holds the next I fill word.
- i_done  output  1  one-cycle pulse with the final I beat.
- d_req  input  1  data request; level, held until d_done.
- d_we  input  1  1 = single-word write, 0 = line read.
- d_addr  input  32  data address; aligned as for i_addr on reads.
- d_wdata  input  32  write data; stable while d_req is high.
- d_beat  output  1  one-cycle pulse: rd_data holds the next D read word.
- d_done  output  1  one-cycle pulse at read or write completion.
- rd_data  output  32  registered read word, shared by both sides.
- Bus  inout  32  memory data bus; driven only in DWRITE, else high-Z.
- Addr  output  32  memory address.
- Read  output  1  bus read strobe.
- Write  output  1  bus write strobe.
- Valid  input  1  memory beat acknowledge.
- busy  output  1  high in any state other than IDLE.
- stat_ifill, stat_dread, stat_dwrite, stat_wait  output  32 each  statistics counters; see Optional Feature.

Behaviour:
- States: IDLE, IREAD, DREAD, DWRITE, TURN.
- Reset values (MRST_N=0 at posedge): state=IDLE; Addr=0; Read=Write=0; Bus high-Z; rd_data=0; all pulses 0; beat counter=0; dstreak=0.
- Reset mid-transfer abandons the transfer silently; no done pulse is generated.
- Arbitration happens in IDLE only and is decided from inputs sampled at that posedge.
  - d_req && !(i_req && dstreak==MAX_DSTREAK): go to DWRITE if d_we, else DREAD.
  - Otherwise, if i_req: go to IREAD.
- dstreak handling:
  - +1 on each D grant while i_req=1, saturating at MAX_DSTREAK.
  - Cleared on each I grant.
  - Cleared on each D grant while i_req=0.
- On grant: next cycle Addr = base address, beat counter = 0, Read or Write asserted.
  - Bus address phase begins the cycle after the request is seen, so minimum latency request→first strobe is 1 cycle.
- Read beat:
  - Read held high; Addr = base + 4*beat.
  - Valid=1 at a posedge: rd_data <= Bus; pulse i_beat/d_beat the following cycle; beat increments and Addr advances.
  - Valid=0 stalls indefinitely; Addr and Read hold.
- Last read beat (beat==LINE_WORDS-1 with Valid): *_done pulses together with the last *_beat.
  - Read drops, state → IDLE, so a new grant is possible on the cycle of the done pulse.
- DWRITE:
  - Write=1, Bus=d_wdata, Addr=d_addr.
  - On Valid: d_done pulses next cycle, Write drops, Bus released, state → TURN.
- TURN: one idle cycle (bus turnaround), then → IDLE. No grant is made in TURN.
- Valid is ignored in IDLE and TURN.
- Beat counter width is clog2(LINE_WORDS), minimum 1 bit. Address add is 32-bit modulo; wraps silently at 0xFFFFFFFC.
- A requester that drops its req mid-transfer is not aborted; the transfer completes. Requesters must not do this.
- Read and Write are never high together.
- Exactly one *_done pulse per grant.

Optional Feature:
- Macro: BUS_ARB_STATS_EN.
- When defined, four counters are built; each is 32-bit, reset to 0, and wraps.
  - stat_ifill: +1 per I done.
  - stat_dread: +1 per D read done.
  - stat_dwrite: +1 per D write done.
  - stat_wait: +1 per cycle with Read|Write high and Valid=0.
- When undefined, the counters are not built and the four ports are tied to 0. Port list is unchanged.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=0, IREAD=1, DREAD=2, DWRITE=3, TURN=4, 3-bit.
  - Requester-id constants: REQ_I=0, REQ_D=1.
- One natural sub-module: mem_bus_arb_prio.
  - Combinational grant decision plus the registered dstreak counter.
  - Inputs: i_req, d_req, idle, grant strobe. Output: grant id.

Test Plan:
- Reset: MRST_N low 2 cycles during an IREAD → Read=0, Bus=Z, busy=0, no i_done; then i_req @0x100 restarts the fill from 0x100.
- I fill with LINE_WORDS=4, Valid every cycle, data 0xA0..0xA3 → Addr 0x100,0x104,0x108,0x10C; four i_beat pulses with rd_data 0xA0..0xA3; i_done on the 4th beat.
- D write 0xDEADBEEF @0x2000, Valid after 3 wait cycles → Write high 4 cycles, Bus=0xDEADBEEF, d_done once, one TURN cycle, stat_wait=3 with stats enabled.
- Simultaneous i_req and d_req (read) in IDLE → DREAD granted first, then IREAD.
- Starvation, MAX_DSTREAK=4: d_req held continuously alongside i_req → 4 D grants, 5th grant is I, then D resumes.
- Stall: Valid low 10 cycles mid-line → Addr and Read hold, no beat pulses, stat_wait+=10.
